// File: rtl/data_memory_mmio_pkg.sv
// Shared types, MMIO address map and RV32I load/store width helpers for data_memory_mmio.
package data_memory_mmio_pkg;

  localparam logic [31:0] MMIO_LED_ADDR    = 32'hFFFF_FFFC;
  localparam logic [31:0] MMIO_MICROS_ADDR = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_MILLIS_ADDR = 32'hFFFF_FFF4;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } mem_funct3_t;

  // Store codes share their encodings with the matching loads.
  localparam mem_funct3_t F3_SB = F3_LB;
  localparam mem_funct3_t F3_SH = F3_LH;
  localparam mem_funct3_t F3_SW = F3_LW;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_SB:   d = {4{wd[7:0]}};
      F3_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'd0, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_mmio_led_pwm.sv
// One PWM channel: registered compare of the shared free-running counter against a duty value.
module led_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  // Output high while the counter is below the duty value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Unified RAM with byte-masked stores and 1-cycle reads, plus LED PWM and us/ms timer MMIO registers.
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int    DEPTH_WORDS = 2048,
  parameter string INIT_FILE   = "",
  parameter int    CLK_FREQ_HZ = 12_000_000,
  parameter int    PWM_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wen,
  input  logic [31:0] mem_wa,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_ra,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_rd,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int MS_DIV = CLK_FREQ_HZ / 1000;

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q;

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_ram;
  logic        wr_led;

  logic        rd_is_ram;
  logic [31:0] rd_mmio;
  logic        rd_is_ram_r;
  logic [31:0] rd_mmio_r;
  logic [2:0]  rd_f3_r;
  logic [1:0]  rd_off_r;

  logic [31:0] led_reg;
  logic [31:0] us_pre_r;
  logic [31:0] ms_pre_r;
  logic [31:0] micros_r;
  logic [31:0] millis_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;

  // Store decode: byte enables, lane-replicated data and target region.
  always_comb begin
    wr_be   = store_be(mem_funct3, mem_wa[1:0]);
    wr_data = store_data(mem_funct3, mem_wd);
    wr_ram  = mem_wen && !rst && (mem_wa[31:2] < 30'(DEPTH_WORDS));
    wr_led  = mem_wen && !rst && ({mem_wa[31:2], 2'b00} == MMIO_LED_ADDR);
  end

  // Block RAM: byte-masked write with read-before-write on the registered read port.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          ram[mem_wa[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    ram_q <= ram[mem_ra[AW+1:2]];
  end

  // Read region decode; unmapped addresses read as zero.
  always_comb begin
    rd_is_ram = 1'b0;
    rd_mmio   = 32'd0;
    if (mem_ra[31:2] < 30'(DEPTH_WORDS)) begin
      rd_is_ram = 1'b1;
    end else if ({mem_ra[31:2], 2'b00} == MMIO_LED_ADDR) begin
      rd_mmio = led_reg;
    end else if ({mem_ra[31:2], 2'b00} == MMIO_MICROS_ADDR) begin
      rd_mmio = micros_r;
    end else if ({mem_ra[31:2], 2'b00} == MMIO_MILLIS_ADDR) begin
      rd_mmio = millis_r;
    end else begin
      rd_mmio = 32'd0;
    end
  end

  // Capture read context alongside the RAM read so extraction matches the sampled load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_is_ram_r <= 1'b0;
      rd_mmio_r   <= 32'd0;
      rd_f3_r     <= 3'd0;
      rd_off_r    <= 2'd0;
    end else begin
      rd_is_ram_r <= rd_is_ram;
      rd_mmio_r   <= rd_mmio;
      rd_f3_r     <= mem_funct3;
      rd_off_r    <= mem_ra[1:0];
    end
  end

  assign mem_rd = load_extract(rd_is_ram_r ? ram_q : rd_mmio_r, rd_f3_r, rd_off_r);

  // LED duty register with the same byte-enable rules as RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= 32'd0;
    end else if (wr_led) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          led_reg[8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end else begin
      led_reg <= led_reg;
    end
  end

  // Microsecond / millisecond prescalers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      us_pre_r <= 32'd0;
      ms_pre_r <= 32'd0;
      micros_r <= 32'd0;
      millis_r <= 32'd0;
    end else begin
      if (us_pre_r == 32'(US_DIV - 1)) begin
        us_pre_r <= 32'd0;
        micros_r <= micros_r + 32'd1;
      end else begin
        us_pre_r <= us_pre_r + 32'd1;
      end
      if (ms_pre_r == 32'(MS_DIV - 1)) begin
        ms_pre_r <= 32'd0;
        millis_r <= millis_r + 32'd1;
      end else begin
        ms_pre_r <= ms_pre_r + 32'd1;
      end
    end
  end

  // Shared free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end
  end

  led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk (clk), .rst (rst), .cnt (pwm_cnt_r), .duty (led_reg[0 +: PWM_BITS]), .pwm (led_r)
  );
  led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_g (
    .clk (clk), .rst (rst), .cnt (pwm_cnt_r), .duty (led_reg[8 +: PWM_BITS]), .pwm (led_g)
  );
  led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk (clk), .rst (rst), .cnt (pwm_cnt_r), .duty (led_reg[16 +: PWM_BITS]), .pwm (led_b)
  );

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed self-checking bench for data_memory_mmio (RAM loads/stores, timers, LED PWM, reset).
module tb_data_memory_mmio;

  logic        clk;
  logic        rst;
  logic        mem_wen;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  logic [31:0] mem_ra;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd;
  logic        led_r;
  logic        led_g;
  logic        led_b;

  int checks;
  int failures;
  logic [31:0] rd;
  int cnt_r, cnt_g, cnt_b;

  data_memory_mmio #(
    .DEPTH_WORDS (2048),
    .INIT_FILE   (""),
    .CLK_FREQ_HZ (4_000_000),
    .PWM_BITS    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wen    (mem_wen),
    .mem_wa     (mem_wa),
    .mem_wd     (mem_wd),
    .mem_ra     (mem_ra),
    .mem_funct3 (mem_funct3),
    .mem_rd     (mem_rd),
    .led_r      (led_r),
    .led_g      (led_g),
    .led_b      (led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    mem_wen    = 1'b1;
    mem_wa     = addr;
    mem_wd     = data;
    mem_funct3 = f3;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, output logic [31:0] data);
    mem_ra     = addr;
    mem_funct3 = f3;
    @(posedge clk);
    #1;
    data = mem_rd;
  endtask

  task automatic count_leds(input int cycles);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      cnt_r += int'(led_r);
      cnt_g += int'(led_g);
      cnt_b += int'(led_b);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    mem_wen = 1'b0;
    mem_wa = 32'd0;
    mem_wd = 32'd0;
    mem_ra = 32'd0;
    mem_funct3 = 3'b010;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd", mem_rd, 32'd0);
    check("reset_leds", {29'd0, led_r, led_g, led_b}, 32'd0);
    rst = 1'b0;

    // Word store / load
    do_store(32'h100, 32'hDEADBEEF, 3'b010);
    do_load(32'h100, 3'b010, rd);
    check("lw_deadbeef", rd, 32'hDEADBEEF);

    // Byte store and byte/half/word loads
    do_store(32'h100, 32'h11223344, 3'b010);
    do_store(32'h103, 32'h00000080, 3'b000);
    do_load(32'h103, 3'b000, rd);
    check("lb_103", rd, 32'hFFFFFF80);
    do_load(32'h103, 3'b100, rd);
    check("lbu_103", rd, 32'h00000080);
    do_load(32'h100, 3'b010, rd);
    check("lw_after_sb", rd, 32'h80223344);
    do_load(32'h102, 3'b001, rd);
    check("lh_102", rd, 32'hFFFF8022);
    do_load(32'h100, 3'b100, rd);
    check("lbu_100", rd, 32'h00000044);
    do_load(32'h101, 3'b110, rd);
    check("lw_f3_110", rd, 32'h80223344);

    // Half store
    do_store(32'h200, 32'h00000000, 3'b010);
    do_store(32'h202, 32'h1234ABCD, 3'b001);
    do_load(32'h202, 3'b001, rd);
    check("lh_202", rd, 32'hFFFFABCD);
    do_load(32'h200, 3'b101, rd);
    check("lhu_200", rd, 32'h00000000);
    do_load(32'h203, 3'b101, rd);
    check("lhu_203", rd, 32'h0000ABCD);
    do_load(32'h200, 3'b010, rd);
    check("lw_200", rd, 32'hABCD0000);

    // Read-before-write on the same word and edge
    do_store(32'h40, 32'h00000001, 3'b010);
    mem_wen = 1'b1;
    mem_wa = 32'h40;
    mem_wd = 32'h00000005;
    mem_ra = 32'h40;
    mem_funct3 = 3'b010;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    check("rbw_old", mem_rd, 32'h00000001);
    do_load(32'h40, 3'b010, rd);
    check("rbw_new", rd, 32'h00000005);

    // Non-store width code and unmapped accesses
    do_store(32'h40, 32'hFFFFFFFF, 3'b011);
    do_load(32'h40, 3'b010, rd);
    check("no_write_f3_011", rd, 32'h00000005);
    do_store(32'h0000_8000, 32'h12345678, 3'b010);
    do_load(32'h0000_8000, 3'b010, rd);
    check("unmapped_read", rd, 32'h00000000);

    // Timers: 4 clk per us, 4000 clk per ms
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4000) @(posedge clk);
    #1;
    do_load(32'hFFFF_FFF8, 3'b010, rd);
    check("micros_4000", rd, 32'd1000);
    do_load(32'hFFFF_FFF4, 3'b010, rd);
    check("millis_4000", rd, 32'd1);
    do_store(32'hFFFF_FFF8, 32'h12345678, 3'b010);
    do_load(32'hFFFF_FFF8, 3'b010, rd);
    check("micros_ro", rd, 32'd1000);
    do_store(32'hFFFF_FFF4, 32'h12345678, 3'b010);
    do_load(32'hFFFF_FFF4, 3'b010, rd);
    check("millis_ro", rd, 32'd1);

    // LED PWM duty counts over a full 256-cycle period
    do_store(32'hFFFF_FFFC, 32'h00FF4000, 3'b010);
    do_load(32'hFFFF_FFFC, 3'b010, rd);
    check("led_reg", rd, 32'h00FF4000);
    repeat (2) @(posedge clk);
    #1;
    count_leds(256);
    check("pwm_r_0", 32'(cnt_r), 32'd0);
    check("pwm_g_64", 32'(cnt_g), 32'd64);
    check("pwm_b_255", 32'(cnt_b), 32'd255);

    // Byte store into the LED register
    do_store(32'hFFFF_FFFD, 32'h00000010, 3'b000);
    do_load(32'hFFFF_FFFC, 3'b010, rd);
    check("led_reg_sb", rd, 32'h00FF1000);
    repeat (2) @(posedge clk);
    #1;
    count_leds(256);
    check("pwm_g_16", 32'(cnt_g), 32'd16);

    // Reset mid-window drops a pending store and clears MMIO state
    count_leds(50);
    rst = 1'b1;
    mem_wen = 1'b1;
    mem_wa = 32'h100;
    mem_wd = 32'h00000077;
    mem_funct3 = 3'b010;
    mem_ra = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    mem_wen = 1'b0;
    check("rst_leds", {29'd0, led_r, led_g, led_b}, 32'd0);
    check("rst_rd", mem_rd, 32'd0);
    rst = 1'b0;
    do_load(32'hFFFF_FFFC, 3'b010, rd);
    check("rst_led_reg", rd, 32'd0);
    do_load(32'h100, 3'b010, rd);
    check("rst_store_dropped", rd, 32'h80223344);
    do_load(32'hFFFF_FFF8, 3'b010, rd);
    check("rst_micros", rd, 32'd0);
    count_leds(256);
    check("rst_pwm_off", 32'(cnt_r + cnt_g + cnt_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
